inst_fetch: RTL and testbench



---
 rtl/inst_fetch_pkg.sv | 21 ++
 rtl/inst_fetch_if.sv | 24 ++
 rtl/inst_fetch_pc_reg.sv | 45 ++++
 rtl/inst_fetch.sv | 65 ++++++
 tb/tb_inst_fetch.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types for the instruction-fetch stage.
// Default widths, FSM state encoding and the IF/ID bundle.
package if_pkg;

    localparam int NPC_DEF   = 6;
    localparam int NINST_DEF = 32;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } fetch_state_e;

    typedef logic [NPC_DEF-1:0] pc_t;

    typedef struct packed {
        pc_t                  pc;
        logic [NINST_DEF-1:0] inst;
        logic                 valid;
    } if_id_t;

endpackage

// File: rtl/inst_fetch_if.sv
// Instruction ROM port: fetch stage is master, ROM is slave.
// ROM data is combinational from ce/addr.
interface inst_fetch_if #(
    parameter int NPC   = if_pkg::NPC_DEF,
    parameter int NINST = if_pkg::NINST_DEF
);

    logic             ce;
    logic [NPC-1:0]   addr;
    logic [NINST-1:0] inst;

    modport master (
        output ce,
        output addr,
        input  inst
    );

    modport slave (
        input  ce,
        input  addr,
        output inst
    );

endinterface

// File: rtl/inst_fetch_pc_reg.sv
// Fetch FSM and program counter with flush > stall > branch > seq.
// ROM enable/address decode only from registered state and pc.
module pc_reg
    import if_pkg::*;
#(
    parameter int NPC = if_pkg::NPC_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stall,
    input  logic           flush,
    input  logic [NPC-1:0] flush_pc,
    input  logic           branch_valid,
    input  logic [NPC-1:0] branch_target,
    output logic           rom_ce,
    output logic [NPC-1:0] rom_addr
);

    fetch_state_e   state;
    logic [NPC-1:0] pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            pc    <= '0;
        end else begin
            unique case (state)
                S_IDLE: state <= S_RUN;
                S_RUN: begin
                    priority case (1'b1)
                        flush:        pc <= flush_pc;
                        stall:        pc <= pc;
                        branch_valid: pc <= branch_target;
                        default:      pc <= pc + {{(NPC-1){1'b0}}, 1'b1};
                    endcase
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign rom_ce   = (state == S_RUN);
    assign rom_addr = pc;

endmodule

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: drives the ROM and owns the IF/ID register.
// The word fetched on a branch edge is the delay slot and stays valid.
module inst_fetch
    import if_pkg::*;
#(
    parameter int NPC   = if_pkg::NPC_DEF,
    parameter int NINST = if_pkg::NINST_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall,
    input  logic             i_flush,
    input  logic [NPC-1:0]   i_flush_pc,
    input  logic             i_branch_valid,
    input  logic [NPC-1:0]   i_branch_target,
    inst_fetch_if.master     rom,
    output logic [NPC-1:0]   o_id_pc,
    output logic [NINST-1:0] o_id_inst,
    output logic             o_id_valid
);

    typedef struct packed {
        logic [NPC-1:0]   pc;
        logic [NINST-1:0] inst;
        logic             valid;
    } id_reg_t;

    id_reg_t        id_q;
    logic           ce;
    logic [NPC-1:0] addr;

    pc_reg #(
        .NPC(NPC)
    ) u_pc_reg (
        .clk          (i_clk),
        .rst          (i_rst),
        .stall        (i_stall),
        .flush        (i_flush),
        .flush_pc     (i_flush_pc),
        .branch_valid (i_branch_valid),
        .branch_target(i_branch_target),
        .rom_ce       (ce),
        .rom_addr     (addr)
    );

    assign rom.ce   = ce;
    assign rom.addr = addr;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            id_q <= '0;
        end else if (ce) begin
            if (i_flush) begin
                id_q <= '0;
            end else if (!i_stall) begin
                id_q <= '{pc: addr, inst: rom.inst, valid: 1'b1};
            end
        end
    end

    assign o_id_pc    = id_q.pc;
    assign o_id_inst  = id_q.inst;
    assign o_id_valid = id_q.valid;

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: directed stimulus with a scoreboard queue
// of expected (pc, inst) pairs drained by a negedge monitor.
module tb_inst_fetch;

    localparam int NPC   = 6;
    localparam int NINST = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             stall;
    logic             flush;
    logic [NPC-1:0]   flush_pc;
    logic             br_valid;
    logic [NPC-1:0]   br_target;
    logic [NPC-1:0]   id_pc;
    logic [NINST-1:0] id_inst;
    logic             id_valid;

    int checks   = 0;
    int failures = 0;

    logic [NPC+NINST-1:0] exp_q[$];
    logic                 stall_seen = 1'b0;

    inst_fetch_if #(.NPC(NPC), .NINST(NINST)) rom ();

    inst_fetch #(
        .NPC(NPC),
        .NINST(NINST)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_stall        (stall),
        .i_flush        (flush),
        .i_flush_pc     (flush_pc),
        .i_branch_valid (br_valid),
        .i_branch_target(br_target),
        .rom            (rom.master),
        .o_id_pc        (id_pc),
        .o_id_inst      (id_inst),
        .o_id_valid     (id_valid)
    );

    // ROM model: word at address a holds a+1, zero when disabled
    assign rom.inst = rom.ce ? (NINST'(rom.addr) + 32'd1) : '0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int p);
        logic [NPC-1:0] pc;
        pc = NPC'(p);
        exp_q.push_back({pc, NINST'(pc) + 32'd1});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // a stalled edge leaves IF/ID unchanged, so nothing new to pop
    always @(posedge clk) stall_seen = stall && !flush && !rst;

    always @(negedge clk) begin
        if (id_valid && !stall_seen) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_id", {26'd0, id_pc, id_inst}, 64'd0);
            end else begin
                logic [NPC+NINST-1:0] e;
                e = exp_q.pop_front();
                chk("id_stream", {26'd0, id_pc, id_inst}, {26'd0, e});
            end
        end
    end

    initial begin
        rst       = 1'b1;
        stall     = 1'b0;
        flush     = 1'b0;
        flush_pc  = '0;
        br_valid  = 1'b0;
        br_target = '0;

        tick();
        tick();
        @(negedge clk);
        chk("rst_ce", 64'(rom.ce), 64'd0);
        chk("rst_addr", 64'(rom.addr), 64'd0);
        chk("rst_rom_inst", 64'(rom.inst), 64'd0);
        chk("rst_id", {26'd0, id_pc, id_inst}, 64'd0);
        chk("rst_valid", 64'(id_valid), 64'd0);

        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("e0_ce", 64'(rom.ce), 64'd1);
        chk("e0_addr", 64'(rom.addr), 64'd0);
        chk("e0_valid", 64'(id_valid), 64'd0);

        for (int i = 0; i < 4; i++) push(i);
        repeat (4) tick();

        br_valid  = 1'b1;
        br_target = 6'd20;
        push(4);
        tick();
        br_valid = 1'b0;
        push(20);
        tick();

        stall     = 1'b1;
        br_valid  = 1'b1;
        br_target = 6'd40;
        repeat (2) begin
            tick();
            @(negedge clk);
            chk("stbr_id", {26'd0, id_pc, id_inst}, {26'd0, 6'd20, 32'd21});
            chk("stbr_addr", 64'(rom.addr), 64'd21);
        end
        stall = 1'b0;
        push(21);
        tick();
        br_valid = 1'b0;

        for (int i = 40; i < 70; i++) push(i);
        repeat (30) tick();

        stall = 1'b1;
        repeat (3) begin
            tick();
            @(negedge clk);
            chk("stall_id", {26'd0, id_pc, id_inst}, {26'd0, 6'd5, 32'd6});
            chk("stall_addr", 64'(rom.addr), 64'd6);
            chk("stall_valid", 64'(id_valid), 64'd1);
        end
        stall = 1'b0;
        push(6);
        tick();

        flush     = 1'b1;
        flush_pc  = 6'd10;
        stall     = 1'b1;
        br_valid  = 1'b1;
        br_target = 6'd50;
        tick();
        flush    = 1'b0;
        stall    = 1'b0;
        br_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", 64'(id_valid), 64'd0);
        chk("flush_id", {26'd0, id_pc, id_inst}, 64'd0);
        chk("flush_addr", 64'(rom.addr), 64'd10);

        for (int i = 10; i < 30; i++) push(i);
        repeat (20) tick();
        @(negedge clk);
        chk("pre_rst_addr", 64'(rom.addr), 64'd30);

        rst       = 1'b1;
        br_valid  = 1'b1;
        br_target = 6'd7;
        tick();
        rst      = 1'b0;
        br_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_ce", 64'(rom.ce), 64'd0);
        chk("mid_rst_addr", 64'(rom.addr), 64'd0);
        chk("mid_rst_id", {26'd0, id_pc, id_inst}, 64'd0);
        chk("mid_rst_valid", 64'(id_valid), 64'd0);

        tick();
        @(negedge clk);
        chk("re_e0_ce", 64'(rom.ce), 64'd1);
        chk("re_e0_addr", 64'(rom.addr), 64'd0);
        chk("re_e0_valid", 64'(id_valid), 64'd0);

        for (int i = 0; i < 4; i++) push(i);
        repeat (4) tick();
        @(negedge clk);
        #2;
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
